// File: rtl/fifo_queue_drainer_if.sv
// Valid/ack handshake bundle shared by the FIFO head port and the downstream port.
// The master drives data and valid, and the slave returns the one-cycle consume/pop pulse.
interface fifo_queue_drainer_if #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32
) ();
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request;
    logic                                  request_valid;
    logic                                  issue_ack;

    modport master (
        output request,
        output request_valid,
        input  issue_ack
    );

    modport slave (
        input  request,
        input  request_valid,
        output issue_ack
    );
endinterface

// File: rtl/fifo_queue_drainer.sv
// Pops a FIFO head with a rate-limited ack pulse and re-presents each entry through
// a 2-entry output buffer using the same valid/ack protocol.
module fifo_queue_drainer #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32,
    parameter int ACK_GAP_CYCLES             = 0
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         enable_in,
    fifo_queue_drainer_if.slave          fifo_if,
    fifo_queue_drainer_if.master         out_if,
    output logic [31:0]                  drain_count_out,
    output logic                         busy_out
);
    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0] drain_cnt_q, drain_cnt_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [W-1:0] buf_q [2];
    logic [W-1:0] buf_d [2];
    logic        capture;
    logic        consume;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= IDLE;
            gap_cnt_q   <= 4'd0;
            drain_cnt_q <= 32'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Buffer storage is not reset; the output mux hides stale entries while count is zero.
    always_ff @(posedge clk_in) begin
        buf_q <= buf_d;
    end

    // Count is sampled at cycle start: a same-cycle consume never frees a slot for capture.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        drain_cnt_d = drain_cnt_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_in && fifo_if.request_valid && (count_q < 2'd2)) begin
                    capture = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                drain_cnt_d = drain_cnt_q + 32'd1;
                if (ACK_GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = 4'(ACK_GAP_CYCLES);
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        buf_d    = buf_q;
        consume  = (count_q != 2'd0) && out_if.issue_ack;
        wr_ptr_d = wr_ptr_q ^ capture;
        rd_ptr_d = rd_ptr_q ^ consume;
        count_d  = count_q + {1'b0, capture} - {1'b0, consume};
        if (capture) begin
            buf_d[wr_ptr_q] = fifo_if.request;
        end
    end

    assign fifo_if.issue_ack    = (state_q == ACK);
    assign out_if.request_valid = (count_q != 2'd0);
    assign out_if.request       = (count_q != 2'd0) ? buf_q[rd_ptr_q] : '0;
    assign drain_count_out      = drain_cnt_q;
    assign busy_out             = (state_q != IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_fifo_queue_drainer.sv
// Directed bench for fifo_queue_drainer: a queue-based FIFO head model feeds two
// instances (gap 0 and gap 3) and each scenario checks hand-computed results.
module tb_fifo_queue_drainer;
    logic clk;
    logic reset_in;
    logic en0, en1;
    logic ds0;
    logic [31:0] drain0, drain1;
    logic        busy0, busy1;

    fifo_queue_drainer_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(32)) fifo_if0 ();
    fifo_queue_drainer_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(32)) out_if0 ();
    fifo_queue_drainer_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(32)) fifo_if1 ();
    fifo_queue_drainer_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(32)) out_if1 ();

    fifo_queue_drainer #(.SINGLE_ENTRY_WIDTH_IN_BITS(32), .ACK_GAP_CYCLES(0)) dut0 (
        .clk_in(clk), .reset_in(reset_in), .enable_in(en0),
        .fifo_if(fifo_if0.slave), .out_if(out_if0.master),
        .drain_count_out(drain0), .busy_out(busy0)
    );

    fifo_queue_drainer #(.SINGLE_ENTRY_WIDTH_IN_BITS(32), .ACK_GAP_CYCLES(3)) dut1 (
        .clk_in(clk), .reset_in(reset_in), .enable_in(en1),
        .fifo_if(fifo_if1.slave), .out_if(out_if1.master),
        .drain_count_out(drain1), .busy_out(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] fifo0[$];
    logic [31:0] fifo1[$];
    int          ack0_cyc[$];
    int          ack1_cyc[$];
    logic [31:0] got0[$];
    logic [31:0] got1[$];

    logic        s_ack0, s_vld0, s_busy0;
    logic [31:0] s_req0, s_drain0;

    task automatic drive_fifos();
        fifo_if0.request_valid = (fifo0.size() != 0);
        fifo_if0.request       = (fifo0.size() != 0) ? fifo0[0] : 32'd0;
        fifo_if1.request_valid = (fifo1.size() != 0);
        fifo_if1.request       = (fifo1.size() != 0) ? fifo1[0] : 32'd0;
        out_if0.issue_ack      = ds0;
        out_if1.issue_ack      = 1'b1;
    endtask

    // Samples at the falling edge, then advances the FIFO models after the rising edge.
    task automatic tick();
        logic a0, a1;
        @(negedge clk);
        a0       = fifo_if0.issue_ack;
        a1       = fifo_if1.issue_ack;
        s_ack0   = a0;
        s_vld0   = out_if0.request_valid;
        s_req0   = out_if0.request;
        s_busy0  = busy0;
        s_drain0 = drain0;
        if (a0) ack0_cyc.push_back(cyc);
        if (a1) ack1_cyc.push_back(cyc);
        if (out_if0.request_valid && out_if0.issue_ack) got0.push_back(out_if0.request);
        if (out_if1.request_valid && out_if1.issue_ack) got1.push_back(out_if1.request);
        @(posedge clk);
        #1;
        cyc++;
        if (a0 && fifo0.size() != 0) void'(fifo0.pop_front());
        if (a1 && fifo1.size() != 0) void'(fifo1.pop_front());
        drive_fifos();
    endtask

    task automatic do_reset();
        en0 = 1'b0;
        en1 = 1'b0;
        ds0 = 1'b0;
        fifo0.delete(); fifo1.delete();
        ack0_cyc.delete(); ack1_cyc.delete();
        got0.delete(); got1.delete();
        drive_fifos();
        @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        reset_in = 1'b1;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        en0 = 1'b0; en1 = 1'b0; ds0 = 1'b0;
        drive_fifos();
        #12;
        n_cmp++; if (fifo_if0.issue_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", fifo_if0.issue_ack); end
        n_cmp++; if (out_if0.request_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", out_if0.request_valid); end
        n_cmp++; if (out_if0.request !== 32'd0) begin n_bad++; $display("FAIL reset_request got=%h exp=0", out_if0.request); end
        n_cmp++; if (drain0 !== 32'd0) begin n_bad++; $display("FAIL reset_drain got=%0d exp=0", drain0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    endtask

    task automatic test_single();
        do_reset();
        ds0 = 1'b1;
        fifo0.push_back(32'hFFFF_FFFF);
        en0 = 1'b1;
        drive_fifos();
        tick();
        n_cmp++; if (s_ack0 !== 1'b1) begin n_bad++; $display("FAIL single_ack got=%b exp=1", s_ack0); end
        n_cmp++; if (s_vld0 !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", s_vld0); end
        n_cmp++; if (s_req0 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL single_data got=%h exp=ffffffff", s_req0); end
        tick();
        n_cmp++; if (s_ack0 !== 1'b0) begin n_bad++; $display("FAIL single_ack_low got=%b exp=0", s_ack0); end
        n_cmp++; if (s_busy0 !== 1'b0) begin n_bad++; $display("FAIL single_busy got=%b exp=0", s_busy0); end
        n_cmp++; if (s_drain0 !== 32'd1) begin n_bad++; $display("FAIL single_drain got=%0d exp=1", s_drain0); end
    endtask

    task automatic test_burst();
        do_reset();
        ds0 = 1'b1;
        for (int i = 0; i < 8; i++) fifo0.push_back(32'hFFFF_FFFF - 32'(i));
        en0 = 1'b1;
        drive_fifos();
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if (ack0_cyc.size() !== 8) begin n_bad++; $display("FAIL burst_pulses got=%0d exp=8", ack0_cyc.size()); end
        for (int i = 1; i < ack0_cyc.size(); i++) begin
            n_cmp++;
            if (ack0_cyc[i] - ack0_cyc[i-1] !== 2) begin
                n_bad++; $display("FAIL burst_spacing[%0d] got=%0d exp=2", i, ack0_cyc[i] - ack0_cyc[i-1]);
            end
        end
        n_cmp++; if (got0.size() !== 8) begin n_bad++; $display("FAIL burst_received got=%0d exp=8", got0.size()); end
        for (int i = 0; i < got0.size() && i < 8; i++) begin
            n_cmp++;
            if (got0[i] !== 32'hFFFF_FFFF - 32'(i)) begin
                n_bad++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, got0[i], 32'hFFFF_FFFF - 32'(i));
            end
        end
        n_cmp++; if (s_drain0 !== 32'd8) begin n_bad++; $display("FAIL burst_drain got=%0d exp=8", s_drain0); end
    endtask

    task automatic test_stall();
        do_reset();
        ds0 = 1'b0;
        for (int i = 0; i < 4; i++) fifo0.push_back(32'hC0DE_0000 + 32'(i));
        en0 = 1'b1;
        drive_fifos();
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (ack0_cyc.size() !== 2) begin n_bad++; $display("FAIL stall_pops got=%0d exp=2", ack0_cyc.size()); end
        n_cmp++; if (s_ack0 !== 1'b0) begin n_bad++; $display("FAIL stall_ack got=%b exp=0", s_ack0); end
        n_cmp++; if (s_req0 !== 32'hC0DE_0000) begin n_bad++; $display("FAIL stall_head got=%h exp=c0de0000", s_req0); end
        n_cmp++; if (s_drain0 !== 32'd2) begin n_bad++; $display("FAIL stall_drain got=%0d exp=2", s_drain0); end
        ds0 = 1'b1;
        drive_fifos();
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (got0.size() !== 4) begin n_bad++; $display("FAIL stall_received got=%0d exp=4", got0.size()); end
        for (int i = 0; i < got0.size() && i < 4; i++) begin
            n_cmp++;
            if (got0[i] !== 32'hC0DE_0000 + 32'(i)) begin
                n_bad++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, got0[i], 32'hC0DE_0000 + 32'(i));
            end
        end
        n_cmp++; if (s_drain0 !== 32'd4) begin n_bad++; $display("FAIL stall_final_drain got=%0d exp=4", s_drain0); end
        n_cmp++; if (s_busy0 !== 1'b0) begin n_bad++; $display("FAIL stall_busy got=%b exp=0", s_busy0); end
    endtask

    task automatic test_gap();
        do_reset();
        for (int i = 0; i < 4; i++) fifo1.push_back(32'hA000_0000 + 32'(i));
        en1 = 1'b1;
        drive_fifos();
        for (int i = 0; i < 30; i++) tick();
        n_cmp++; if (ack1_cyc.size() !== 4) begin n_bad++; $display("FAIL gap_pulses got=%0d exp=4", ack1_cyc.size()); end
        for (int i = 1; i < ack1_cyc.size(); i++) begin
            n_cmp++;
            if (ack1_cyc[i] - ack1_cyc[i-1] !== 5) begin
                n_bad++; $display("FAIL gap_spacing[%0d] got=%0d exp=5", i, ack1_cyc[i] - ack1_cyc[i-1]);
            end
        end
        for (int i = 0; i < got1.size() && i < 4; i++) begin
            n_cmp++;
            if (got1[i] !== 32'hA000_0000 + 32'(i)) begin
                n_bad++; $display("FAIL gap_data[%0d] got=%h exp=%h", i, got1[i], 32'hA000_0000 + 32'(i));
            end
        end
        n_cmp++; if (drain1 !== 32'd4) begin n_bad++; $display("FAIL gap_drain got=%0d exp=4", drain1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL gap_busy got=%b exp=0", busy1); end
    endtask

    task automatic test_enable();
        do_reset();
        ds0 = 1'b1;
        for (int i = 0; i < 4; i++) fifo0.push_back(32'h5EED_0000 + 32'(i));
        en0 = 1'b1;
        drive_fifos();
        @(posedge clk);
        #1;
        en0 = 1'b0;
        tick();
        n_cmp++; if (s_ack0 !== 1'b1) begin n_bad++; $display("FAIL enable_inflight_ack got=%b exp=1", s_ack0); end
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (ack0_cyc.size() !== 1) begin n_bad++; $display("FAIL enable_off_pulses got=%0d exp=1", ack0_cyc.size()); end
        n_cmp++; if (s_drain0 !== 32'd1) begin n_bad++; $display("FAIL enable_off_drain got=%0d exp=1", s_drain0); end
        n_cmp++; if (s_busy0 !== 1'b0) begin n_bad++; $display("FAIL enable_off_busy got=%b exp=0", s_busy0); end
        n_cmp++; if (got0.size() !== 1) begin n_bad++; $display("FAIL enable_off_drained got=%0d exp=1", got0.size()); end
        en0 = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (ack0_cyc.size() !== 4) begin n_bad++; $display("FAIL enable_on_pulses got=%0d exp=4", ack0_cyc.size()); end
        for (int i = 0; i < got0.size() && i < 4; i++) begin
            n_cmp++;
            if (got0[i] !== 32'h5EED_0000 + 32'(i)) begin
                n_bad++; $display("FAIL enable_data[%0d] got=%h exp=%h", i, got0[i], 32'h5EED_0000 + 32'(i));
            end
        end
        n_cmp++; if (s_drain0 !== 32'd4) begin n_bad++; $display("FAIL enable_on_drain got=%0d exp=4", s_drain0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ds0 = 1'b0;
        for (int i = 0; i < 4; i++) fifo0.push_back(32'h1111_0000 + 32'(i));
        en0 = 1'b1;
        drive_fifos();
        tick();
        tick();
        // Now inside the second ACK cycle with two entries held in the buffer.
        n_cmp++; if (fifo_if0.issue_ack !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_ack got=%b exp=1", fifo_if0.issue_ack); end
        #2;
        reset_in = 1'b0;
        #1;
        n_cmp++; if (fifo_if0.issue_ack !== 1'b0) begin n_bad++; $display("FAIL midrst_ack got=%b exp=0", fifo_if0.issue_ack); end
        n_cmp++; if (out_if0.request_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b exp=0", out_if0.request_valid); end
        n_cmp++; if (out_if0.request !== 32'd0) begin n_bad++; $display("FAIL midrst_request got=%h exp=0", out_if0.request); end
        n_cmp++; if (drain0 !== 32'd0) begin n_bad++; $display("FAIL midrst_drain got=%0d exp=0", drain0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy0); end
        reset_in = 1'b1;
        ack0_cyc.delete();
        got0.delete();
        ds0 = 1'b1;
        drive_fifos();
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (got0.size() !== 3) begin n_bad++; $display("FAIL midrst_received got=%0d exp=3", got0.size()); end
        n_cmp++; if (got0.size() == 0 || got0[0] !== 32'h1111_0001) begin
            n_bad++; $display("FAIL midrst_first got=%h exp=11110001", (got0.size() != 0) ? got0[0] : 32'hx);
        end
        n_cmp++; if (s_drain0 !== 32'd3) begin n_bad++; $display("FAIL midrst_drain_after got=%0d exp=3", s_drain0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_gap();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
